nand3_exerciser: RTL and testbench

- Stimulus driver and response checker for 3-input library cells: the driving end of a cell's A1/A2/A3 inputs and the receiving end of its Y output.
- Walks all 8 input vectors, waits a programmable settle time, samples Y and compares it with a truth-table parameter.
- Used for bring-up and self-test of hand-built cells on the board and in gate-level sim; default truth table is NAND3.

---
 rtl/nand3_exerciser.sv | 174 +++++++++++++++++
 tb/tb_nand3_exerciser.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/nand3_exerciser.sv
// Drives all 8 input vectors into a 3-input cell, samples Y after a settle
// delay and counts mismatches against TRUTH. NAND3_EXERCISER_FAILLOG_EN adds first-failure capture.
module nand3_exerciser #(
  parameter logic [7:0] TRUTH         = 8'h7F,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         LOOPS         = 1,
  parameter int         ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  input  logic             Y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       fail_vec,
  output logic             fail_y
);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE
  } state_t;

  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'((LOOPS > 0) ? LOOPS - 1 : 0);
  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;
  localparam logic [ERR_W-1:0]  ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [2:0]         vec_q, vec_d;
  logic [LOOP_W-1:0]  loop_q, loop_d;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [ERR_W-1:0]   err_next;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               mismatch;
`ifdef NAND3_EXERCISER_FAILLOG_EN
  logic [2:0]         fail_vec_q, fail_vec_d;
  logic               fail_y_q, fail_y_d;
`endif

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    loop_d   = loop_q;
    settle_d = settle_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
`ifdef NAND3_EXERCISER_FAILLOG_EN
    fail_vec_d = fail_vec_q;
    fail_y_d   = fail_y_q;
`endif
    mismatch = (Y != TRUTH[vec_q]);
    err_next = err_q;
    if (mismatch && (err_q != ERR_MAX)) begin
      err_next = err_q + ERR_ONE;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_APPLY;
          vec_d    = 3'd0;
          loop_d   = '0;
          err_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
`ifdef NAND3_EXERCISER_FAILLOG_EN
          fail_vec_d = 3'd0;
          fail_y_d   = 1'b0;
`endif
        end
      end
      S_APPLY: begin
        settle_d = '0;
        state_d  = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_SAMPLE: begin
        err_d = err_next;
`ifdef NAND3_EXERCISER_FAILLOG_EN
        // Only the first mismatch of a run is logged.
        if (mismatch && (err_q == '0)) begin
          fail_vec_d = vec_q;
          fail_y_d   = Y;
        end
`endif
        if (vec_q == 3'd7) begin
          if (loop_q == LOOP_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_next == '0);
          end else begin
            state_d = S_APPLY;
            vec_d   = 3'd0;
            loop_d  = loop_q + {{(LOOP_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = S_APPLY;
          vec_d   = vec_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= 3'd0;
      loop_q   <= '0;
      settle_q <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      loop_q   <= loop_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

`ifdef NAND3_EXERCISER_FAILLOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_vec_q <= 3'd0;
      fail_y_q   <= 1'b0;
    end else begin
      fail_vec_q <= fail_vec_d;
      fail_y_q   <= fail_y_d;
    end
  end

  assign fail_vec = fail_vec_q;
  assign fail_y   = fail_y_q;
`else
  assign fail_vec = 3'd0;
  assign fail_y   = 1'b0;
`endif

  // The vector register drives the cell directly so A1..A3 stay glitch-free.
  assign A1      = vec_q[0];
  assign A2      = vec_q[1];
  assign A3      = vec_q[2];
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_nand3_exerciser.sv
// Directed bench for nand3_exerciser: several parameterisations run side by side
// against ideal, stuck and delayed cell models.
module tb_nand3_exerciser;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [1:0] y_mode;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u0: defaults, Y from y_mode (0 ideal NAND3, 1 stuck-1)
  logic a1_0, a2_0, a3_0, y0, busy0, done0, pass0, fy0;
  logic [7:0] err0;
  logic [2:0] fv0;
  assign y0 = (y_mode == 2'd0) ? ~(a1_0 & a2_0 & a3_0) : 1'b1;
  nand3_exerciser u0 (.clk(clk), .rst(rst), .start(start), .A1(a1_0), .A2(a2_0), .A3(a3_0),
    .Y(y0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fv0), .fail_y(fy0));

  // u1: LOOPS=3, Y stuck at 0
  logic a1_1, a2_1, a3_1, busy1, done1, pass1, fy1;
  logic [7:0] err1;
  logic [2:0] fv1;
  nand3_exerciser #(.LOOPS(3)) u1 (.clk(clk), .rst(rst), .start(start), .A1(a1_1), .A2(a2_1),
    .A3(a3_1), .Y(1'b0), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_vec(fv1), .fail_y(fy1));

  // u2: LOOPS=3, ERR_W=4, Y stuck at 0
  logic a1_2, a2_2, a3_2, busy2, done2, pass2, fy2;
  logic [3:0] err2;
  logic [2:0] fv2;
  nand3_exerciser #(.LOOPS(3), .ERR_W(4)) u2 (.clk(clk), .rst(rst), .start(start), .A1(a1_2),
    .A2(a2_2), .A3(a3_2), .Y(1'b0), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .fail_vec(fv2), .fail_y(fy2));

  // u3: SETTLE_CYCLES=0, ideal
  logic a1_3, a2_3, a3_3, busy3, done3, pass3, fy3;
  logic [7:0] err3;
  logic [2:0] fv3;
  nand3_exerciser #(.SETTLE_CYCLES(0)) u3 (.clk(clk), .rst(rst), .start(start), .A1(a1_3),
    .A2(a2_3), .A3(a3_3), .Y(~(a1_3 & a2_3 & a3_3)), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .fail_vec(fv3), .fail_y(fy3));

  // u4: SETTLE_CYCLES=5, ideal
  logic a1_4, a2_4, a3_4, busy4, done4, pass4, fy4;
  logic [7:0] err4;
  logic [2:0] fv4;
  nand3_exerciser #(.SETTLE_CYCLES(5)) u4 (.clk(clk), .rst(rst), .start(start), .A1(a1_4),
    .A2(a2_4), .A3(a3_4), .Y(~(a1_4 & a2_4 & a3_4)), .busy(busy4), .done(done4), .pass(pass4),
    .err_cnt(err4), .fail_vec(fv4), .fail_y(fy4));

  // u5/u6: NAND3 with a 3-cycle output delay, SETTLE_CYCLES=1 and 3
  logic a1_5, a2_5, a3_5, busy5, done5, pass5, fy5;
  logic a1_6, a2_6, a3_6, busy6, done6, pass6, fy6;
  logic [7:0] err5, err6;
  logic [2:0] fv5, fv6, p5, p6;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p5 <= 3'b111;
      p6 <= 3'b111;
    end else begin
      p5 <= {p5[1:0], ~(a1_5 & a2_5 & a3_5)};
      p6 <= {p6[1:0], ~(a1_6 & a2_6 & a3_6)};
    end
  end
  nand3_exerciser #(.SETTLE_CYCLES(1)) u5 (.clk(clk), .rst(rst), .start(start), .A1(a1_5),
    .A2(a2_5), .A3(a3_5), .Y(p5[2]), .busy(busy5), .done(done5), .pass(pass5),
    .err_cnt(err5), .fail_vec(fv5), .fail_y(fy5));
  nand3_exerciser #(.SETTLE_CYCLES(3)) u6 (.clk(clk), .rst(rst), .start(start), .A1(a1_6),
    .A2(a2_6), .A3(a3_6), .Y(p6[2]), .busy(busy6), .done(done6), .pass(pass6),
    .err_cnt(err6), .fail_vec(fv6), .fail_y(fy6));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_u0_reset(input string tag);
    chk({tag, "_a"}, {29'd0, a3_0, a2_0, a1_0}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy0}, 32'd0);
    chk({tag, "_done"}, {31'd0, done0}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass0}, 32'd0);
    chk({tag, "_err"}, {24'd0, err0}, 32'd0);
    chk({tag, "_fail"}, {28'd0, fy0, fv0}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    y_mode = 2'd0;
    tick();
    chk_u0_reset("reset");
    rst = 1'b0;
    tick();

    // Run 1: ideal models, stray start at edge 3 must be ignored
    pulse_start();
    chk("r1_busy0", {31'd0, busy0}, 32'd1);
    chk("r1_done0", {31'd0, done0}, 32'd0);
    for (int c = 1; c <= 96; c++) begin
      start = (c == 3);
      tick();
      if ((c % 4 == 0) && (c <= 28)) chk("r1_vec", {29'd0, a3_0, a2_0, a1_0}, c / 4);
      if (c == 15) chk("s0_done_early", {31'd0, done3}, 32'd0);
      if (c == 16) chk("s0_done_pass", {30'd0, done3, pass3}, 32'd3);
      if (c == 23) chk("dly1_done_early", {31'd0, done5}, 32'd0);
      if (c == 24) chk("dly1_err", {23'd0, done5, err5}, {23'd0, 1'b1, 8'd1});
      if (c == 24) chk("dly1_pass", {31'd0, pass5}, 32'd0);
      if (c == 31) chk("r1_done_early", {30'd0, done0, busy0}, 32'd1);
      if (c == 32) chk("r1_done", {30'd0, done0, busy0}, 32'd2);
      if (c == 32) chk("r1_pass_err", {23'd0, pass0, err0}, {23'd0, 1'b1, 8'd0});
      if (c == 32) chk("r1_last_vec", {29'd0, a3_0, a2_0, a1_0}, 32'd7);
      if (c == 40) chk("dly3_pass", {23'd0, done6, pass6, err6}, {23'd0, 2'b11, 8'd0});
      if (c == 55) chk("s5_done_early", {31'd0, done4}, 32'd0);
      if (c == 56) chk("s5_done_pass", {30'd0, done4, pass4}, 32'd3);
      if (c == 95) chk("loop3_done_early", {31'd0, done1}, 32'd0);
      if (c == 96) chk("loop3_err", {23'd0, done1, err1}, {23'd0, 1'b1, 8'd21});
      if (c == 96) chk("loop3_pass", {31'd0, pass1}, 32'd0);
      if (c == 96) chk("sat_err", {27'd0, done2, err2}, {27'd0, 1'b1, 4'd15});
      if (c == 96) chk("r1_done_hold", {31'd0, done0}, 32'd1);
      if (c == 96) chk("loop3_faillog", {28'd0, fy1, fv1}, 32'd0);
    end

    // Run 2: Y stuck at 1 -> only vector 7 mismatches
    y_mode = 2'd1;
    pulse_start();
    chk("r2_done_clr", {31'd0, done0}, 32'd0);
    repeat (32) tick();
    chk("r2_err", {23'd0, done0, err0}, {23'd0, 1'b1, 8'd1});
    chk("r2_pass", {31'd0, pass0}, 32'd0);
`ifdef NAND3_EXERCISER_FAILLOG_EN
    chk("r2_faillog", {28'd0, fy0, fv0}, {28'd0, 1'b1, 3'd7});
`else
    chk("r2_faillog", {28'd0, fy0, fv0}, 32'd0);
`endif

    // Run 3: restart clears results, then abort with rst at vector 4
    y_mode = 2'd0;
    pulse_start();
    chk("r3_err_clr", {24'd0, err0}, 32'd0);
    chk("r3_fail_clr", {28'd0, fy0, fv0}, 32'd0);
    repeat (16) tick();
    chk("r3_vec4", {29'd0, a3_0, a2_0, a1_0}, 32'd4);
    #2 rst = 1'b1;
    #1 chk_u0_reset("abort");
    tick();
    rst = 1'b0;
    tick();
    chk_u0_reset("abort_idle");

    // Run 4: fresh run from vector 0
    pulse_start();
    chk("r4_busy", {31'd0, busy0}, 32'd1);
    for (int c = 1; c <= 32; c++) begin
      tick();
      if ((c % 4 == 0) && (c <= 28)) chk("r4_vec", {29'd0, a3_0, a2_0, a1_0}, c / 4);
    end
    chk("r4_done", {30'd0, done0, pass0}, 32'd3);
    chk("r4_err", {24'd0, err0}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
